cushion_std_rv32i: RTL and testbench

CUSHION_STD_RV32I -- requirements
Module: cushion_std_rv32i

---
 rtl/cushion_std_rv32i.sv | 124 ++++++++++++
 tb/tb_cushion_std_rv32i.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cushion_std_rv32i.sv
// Writeback cushion: holds one exec result (or a pending load) for a single
// register-file write and forwards it to register read while it is held.
module cushion_std_rv32i (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MMU_WAIT,
  input  logic        EXEC_VALID,
  input  logic [4:0]  EXEC_REG_ADDR,
  input  logic [31:0] EXEC_REG_DATA,
  input  logic        EXEC_LOAD,
  input  logic [1:0]  EXEC_LOAD_SIZE,
  input  logic        EXEC_LOAD_SIGNED,
  input  logic [1:0]  EXEC_LOAD_OFFSET,
  input  logic        MEMR_VALID,
  input  logic [31:0] MEMR_DATA,
  output logic [4:0]  WADDR,
  output logic [31:0] WDATA,
  output logic        FWD_CUSHION_EN,
  output logic [4:0]  FWD_CUSHION_ADDR,
  output logic [31:0] FWD_CUSHION_DATA,
  output logic        STALL_REQ
);

  // state    | meaning
  // IDLE     | no entry held
  // READY    | entry valid, written and forwarded this cycle
  // WAIT_MEM | load captured, waiting for the read word
  // DRAIN    | flushed load, swallowing its outstanding read word
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] READY    = 2'd1;
  localparam logic [1:0] WAIT_MEM = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]  state;
  logic [4:0]  ent_addr;
  logic [31:0] ent_data;
  logic [1:0]  ent_size;
  logic        ent_signed;
  logic [1:0]  ent_off;

  logic        capture;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign capture = EXEC_VALID && !MMU_WAIT && !STALL_REQ && !FLUSH &&
                   ((state == IDLE) || (state == READY));

  always_comb begin
    byte_sel = MEMR_DATA[8*ent_off +: 8];
    half_sel = ent_off[1] ? MEMR_DATA[31:16] : MEMR_DATA[15:0];
    case (ent_size)
      2'b00:   load_val = {{24{ent_signed & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{ent_signed & half_sel[15]}}, half_sel};
      default: load_val = MEMR_DATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ent_addr   <= 5'd0;
      ent_data   <= 32'd0;
      ent_size   <= 2'd0;
      ent_signed <= 1'b0;
      ent_off    <= 2'd0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (capture) begin
            ent_addr   <= EXEC_REG_ADDR;
            ent_data   <= EXEC_REG_DATA;
            ent_size   <= EXEC_LOAD_SIZE;
            ent_signed <= EXEC_LOAD_SIGNED;
            ent_off    <= EXEC_LOAD_OFFSET;
            state      <= EXEC_LOAD ? WAIT_MEM : READY;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (MEMR_VALID) begin
            ent_data <= load_val;
            state    <= FLUSH ? IDLE : READY;
          end else if (FLUSH) begin
            state <= DRAIN;
          end
        end
        default: begin
          if (MEMR_VALID) state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode only from registered state so STALL_REQ has no input path.
  always_comb begin
    WADDR            = 5'd0;
    WDATA            = 32'd0;
    FWD_CUSHION_EN   = 1'b0;
    FWD_CUSHION_ADDR = 5'd0;
    FWD_CUSHION_DATA = 32'd0;
    STALL_REQ        = 1'b0;
    case (state)
      READY: begin
        WADDR            = ent_addr;
        WDATA            = ent_data;
        FWD_CUSHION_EN   = 1'b1;
        FWD_CUSHION_ADDR = ent_addr;
        FWD_CUSHION_DATA = ent_data;
      end
      WAIT_MEM: begin
        FWD_CUSHION_ADDR = ent_addr;
        STALL_REQ        = 1'b1;
      end
      DRAIN: begin
        STALL_REQ = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cushion_std_rv32i.sv
// Directed bench for cushion_std_rv32i: ALU writes, loads, flush, reset cases.
module tb_cushion_std_rv32i;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        MMU_WAIT;
  logic        EXEC_VALID;
  logic [4:0]  EXEC_REG_ADDR;
  logic [31:0] EXEC_REG_DATA;
  logic        EXEC_LOAD;
  logic [1:0]  EXEC_LOAD_SIZE;
  logic        EXEC_LOAD_SIGNED;
  logic [1:0]  EXEC_LOAD_OFFSET;
  logic        MEMR_VALID;
  logic [31:0] MEMR_DATA;
  logic [4:0]  WADDR;
  logic [31:0] WDATA;
  logic        FWD_CUSHION_EN;
  logic [4:0]  FWD_CUSHION_ADDR;
  logic [31:0] FWD_CUSHION_DATA;
  logic        STALL_REQ;

  int n_cmp = 0;
  int n_bad = 0;

  cushion_std_rv32i dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
    .EXEC_VALID(EXEC_VALID), .EXEC_REG_ADDR(EXEC_REG_ADDR),
    .EXEC_REG_DATA(EXEC_REG_DATA), .EXEC_LOAD(EXEC_LOAD),
    .EXEC_LOAD_SIZE(EXEC_LOAD_SIZE), .EXEC_LOAD_SIGNED(EXEC_LOAD_SIGNED),
    .EXEC_LOAD_OFFSET(EXEC_LOAD_OFFSET), .MEMR_VALID(MEMR_VALID),
    .MEMR_DATA(MEMR_DATA), .WADDR(WADDR), .WDATA(WDATA),
    .FWD_CUSHION_EN(FWD_CUSHION_EN), .FWD_CUSHION_ADDR(FWD_CUSHION_ADDR),
    .FWD_CUSHION_DATA(FWD_CUSHION_DATA), .STALL_REQ(STALL_REQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [31:0] d, input logic ld,
                       input logic [1:0] sz, input logic sg, input logic [1:0] off);
    EXEC_VALID       = 1'b1;
    EXEC_REG_ADDR    = a;
    EXEC_REG_DATA    = d;
    EXEC_LOAD        = ld;
    EXEC_LOAD_SIZE   = sz;
    EXEC_LOAD_SIGNED = sg;
    EXEC_LOAD_OFFSET = off;
  endtask

  task automatic quiet();
    EXEC_VALID = 1'b0;
    EXEC_LOAD  = 1'b0;
    MEMR_VALID = 1'b0;
    FLUSH      = 1'b0;
    MMU_WAIT   = 1'b0;
  endtask

  // One load: capture, one idle wait cycle, deliver word, check the written value.
  task automatic load_case(input string tag, input logic [4:0] a, input logic [1:0] sz,
                           input logic sg, input logic [1:0] off,
                           input logic [31:0] word, input logic [31:0] exp);
    issue(a, 32'hDEAD_BEEF, 1'b1, sz, sg, off);
    tick();
    quiet();
    tick();
    MEMR_VALID = 1'b1;
    MEMR_DATA  = word;
    tick();
    quiet();
    chk({tag, "_waddr"}, {27'd0, WADDR}, {27'd0, a});
    chk({tag, "_wdata"}, WDATA, exp);
    tick();
  endtask

  initial begin
    RST = 1'b1;
    EXEC_REG_ADDR = 5'd0; EXEC_REG_DATA = 32'd0; EXEC_LOAD_SIZE = 2'd0;
    EXEC_LOAD_SIGNED = 1'b0; EXEC_LOAD_OFFSET = 2'd0; MEMR_DATA = 32'd0;
    quiet();
    tick(); tick();
    RST = 1'b0;
    chk("rst_waddr", {27'd0, WADDR}, 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_fwd_en", {31'd0, FWD_CUSHION_EN}, 32'd0);
    chk("rst_stall", {31'd0, STALL_REQ}, 32'd0);

    // ALU write
    issue(5'd5, 32'h1234_5678, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    quiet();
    chk("alu_waddr", {27'd0, WADDR}, 32'd5);
    chk("alu_wdata", WDATA, 32'h1234_5678);
    chk("alu_fwd_en", {31'd0, FWD_CUSHION_EN}, 32'd1);
    chk("alu_fwd_addr", {27'd0, FWD_CUSHION_ADDR}, 32'd5);
    chk("alu_fwd_data", FWD_CUSHION_DATA, 32'h1234_5678);
    tick();
    chk("alu_once_waddr", {27'd0, WADDR}, 32'd0);
    chk("alu_once_en", {31'd0, FWD_CUSHION_EN}, 32'd0);

    // Back-to-back
    issue(5'd3, 32'h0000_0033, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    chk("b2b_first", {27'd0, WADDR}, 32'd3);
    issue(5'd4, 32'h0000_0044, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    quiet();
    chk("b2b_second", {27'd0, WADDR}, 32'd4);
    chk("b2b_second_data", WDATA, 32'h0000_0044);
    tick();
    chk("b2b_done", {27'd0, WADDR}, 32'd0);

    // Signed byte load with detailed pending-state checks
    issue(5'd7, 32'hDEAD_BEEF, 1'b1, 2'b00, 1'b1, 2'd2);
    tick();
    quiet();
    chk("ldb_stall", {31'd0, STALL_REQ}, 32'd1);
    chk("ldb_fwd_en", {31'd0, FWD_CUSHION_EN}, 32'd0);
    chk("ldb_waddr", {27'd0, WADDR}, 32'd0);
    chk("ldb_fwd_addr", {27'd0, FWD_CUSHION_ADDR}, 32'd7);
    tick();
    chk("ldb_stall2", {31'd0, STALL_REQ}, 32'd1);
    MEMR_VALID = 1'b1;
    MEMR_DATA  = 32'h0080_FF00;
    tick();
    quiet();
    chk("ldb_waddr_wr", {27'd0, WADDR}, 32'd7);
    chk("ldb_wdata", WDATA, 32'hFFFF_FF80);
    chk("ldb_stall_off", {31'd0, STALL_REQ}, 32'd0);
    chk("ldb_fwd_en_on", {31'd0, FWD_CUSHION_EN}, 32'd1);
    tick();
    chk("ldb_once", {27'd0, WADDR}, 32'd0);

    // Unsigned half load; a new exec result during the wait must not be taken
    issue(5'd9, 32'hDEAD_BEEF, 1'b1, 2'b01, 1'b0, 2'd2);
    tick();
    issue(5'd20, 32'h0000_0020, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    quiet();
    MEMR_VALID = 1'b1;
    MEMR_DATA  = 32'h8001_0000;
    tick();
    quiet();
    chk("ldh_waddr", {27'd0, WADDR}, 32'd9);
    chk("ldh_wdata", WDATA, 32'h0000_8001);
    tick();

    load_case("ldh_s_off1", 5'd11, 2'b01, 1'b1, 2'd1, 32'h1234_8001, 32'hFFFF_8001);
    load_case("ldb_u_off3", 5'd12, 2'b00, 1'b0, 2'd3, 32'hAB00_0000, 32'h0000_00AB);
    load_case("ldb_s_off0", 5'd13, 2'b00, 1'b1, 2'd0, 32'hFFFF_FF7F, 32'h0000_007F);
    load_case("ldw_off3",   5'd14, 2'b10, 1'b1, 2'd3, 32'h8765_4321, 32'h8765_4321);
    load_case("ldw_sz3",    5'd15, 2'b11, 1'b0, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Flush in WAIT_MEM -> DRAIN
    issue(5'd10, 32'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    quiet();
    FLUSH = 1'b1;
    tick();
    quiet();
    chk("drain_stall", {31'd0, STALL_REQ}, 32'd1);
    chk("drain_en", {31'd0, FWD_CUSHION_EN}, 32'd0);
    chk("drain_waddr", {27'd0, WADDR}, 32'd0);
    FLUSH = 1'b1;
    tick();
    quiet();
    chk("drain_flush_ignored", {31'd0, STALL_REQ}, 32'd1);
    tick();
    MEMR_VALID = 1'b1;
    MEMR_DATA  = 32'h5555_5555;
    tick();
    quiet();
    chk("drain_exit_stall", {31'd0, STALL_REQ}, 32'd0);
    chk("drain_exit_waddr", {27'd0, WADDR}, 32'd0);
    tick();
    chk("drain_no_write", {27'd0, WADDR}, 32'd0);

    // Flush together with MEMR_VALID in WAIT_MEM
    issue(5'd16, 32'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    quiet();
    FLUSH = 1'b1; MEMR_VALID = 1'b1; MEMR_DATA = 32'h1111_1111;
    tick();
    quiet();
    chk("flush_mv_waddr", {27'd0, WADDR}, 32'd0);
    chk("flush_mv_stall", {31'd0, STALL_REQ}, 32'd0);

    // Flush in READY blocks a following capture
    issue(5'd6, 32'h0000_0066, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    chk("rdy_flush_cur", {27'd0, WADDR}, 32'd6);
    issue(5'd8, 32'h0000_0088, 1'b0, 2'd0, 1'b0, 2'd0);
    FLUSH = 1'b1;
    tick();
    quiet();
    chk("rdy_flush_next", {27'd0, WADDR}, 32'd0);

    // MMU_WAIT blocks capture in IDLE but not the write in READY
    issue(5'd17, 32'h0000_0017, 1'b0, 2'd0, 1'b0, 2'd0);
    MMU_WAIT = 1'b1;
    tick();
    chk("mmu_block", {27'd0, WADDR}, 32'd0);
    MMU_WAIT = 1'b0;
    tick();
    quiet();
    MMU_WAIT = 1'b1;
    chk("mmu_rdy_write", {27'd0, WADDR}, 32'd17);
    tick();
    chk("mmu_rdy_idle", {27'd0, WADDR}, 32'd0);
    // MMU_WAIT during WAIT_MEM does not disturb the load
    issue(5'd18, 32'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    MMU_WAIT = 1'b0;
    tick();
    quiet();
    MMU_WAIT = 1'b1; MEMR_VALID = 1'b1; MEMR_DATA = 32'h0BAD_F00D;
    tick();
    quiet();
    chk("mmu_wm_waddr", {27'd0, WADDR}, 32'd18);
    chk("mmu_wm_wdata", WDATA, 32'h0BAD_F00D);
    tick();

    // Addr 0 entries
    issue(5'd0, 32'hDEAD_0000, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    quiet();
    chk("x0_waddr", {27'd0, WADDR}, 32'd0);
    chk("x0_fwd_addr", {27'd0, FWD_CUSHION_ADDR}, 32'd0);
    issue(5'd0, 32'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    quiet();
    chk("x0_ld_stall", {31'd0, STALL_REQ}, 32'd1);
    chk("x0_ld_fwd_addr", {27'd0, FWD_CUSHION_ADDR}, 32'd0);
    MEMR_VALID = 1'b1; MEMR_DATA = 32'h7777_7777;
    tick();
    quiet();
    chk("x0_ld_waddr", {27'd0, WADDR}, 32'd0);
    tick();

    // Reset mid-WAIT_MEM, priority over FLUSH
    issue(5'd12, 32'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    quiet();
    chk("rstwm_pre_stall", {31'd0, STALL_REQ}, 32'd1);
    RST = 1'b1; FLUSH = 1'b1;
    tick();
    RST = 1'b0;
    quiet();
    chk("rstwm_stall", {31'd0, STALL_REQ}, 32'd0);
    chk("rstwm_waddr", {27'd0, WADDR}, 32'd0);
    chk("rstwm_fwd_addr", {27'd0, FWD_CUSHION_ADDR}, 32'd0);
    chk("rstwm_fwd_en", {31'd0, FWD_CUSHION_EN}, 32'd0);
    chk("rstwm_wdata", WDATA, 32'd0);
    MEMR_VALID = 1'b1; MEMR_DATA = 32'h9999_9999;
    tick();
    quiet();
    chk("rstwm_late_mv", {27'd0, WADDR}, 32'd0);
    chk("rstwm_late_en", {31'd0, FWD_CUSHION_EN}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
